// File: rtl/ysyx_dmem_responder.sv
// ysyx_dmem_responder: word-addressed data SRAM behind req/rsp valid-ready handshake, configurable latency, range/alignment faults
module ysyx_dmem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = LATENCY > 2 ? $clog2(LATENCY) : 1;
  localparam logic [32:0] LIMIT = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] wmask_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic accept, access, a_wen, fault;
  logic [31:0] a_addr, a_wdata;
  logic [3:0] a_wmask;
  logic [AW-1:0] idx;
  assign req_ready = state == IDLE;
  assign accept = req_valid && req_ready;
  assign a_wen = state == IDLE ? req_wen : wen_q;
  assign a_addr = state == IDLE ? req_addr : addr_q;
  assign a_wdata = state == IDLE ? req_wdata : wdata_q;
  assign a_wmask = state == IDLE ? req_wmask : wmask_q;
  assign fault = a_addr < ADDR_BASE || {1'b0, a_addr} >= LIMIT || a_addr[1:0] != 2'b00;
  assign idx = AW'((a_addr - ADDR_BASE) >> 2);
  always_comb begin
    state_n = state;
    access = 1'b0;
    case (state)
      IDLE: begin
        access = accept && LATENCY == 1;
        state_n = accept ? (LATENCY == 1 ? RESP : BUSY) : IDLE;
      end
      BUSY: begin
        access = cnt == '0;
        state_n = access ? RESP : BUSY;
      end
      RESP: state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      wen_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        wen_q <= req_wen;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        cnt <= CW'(LATENCY > 1 ? LATENCY - 2 : 0);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        rsp_valid <= 1'b1;
        rsp_err <= fault;
        rsp_rdata <= (fault || a_wen) ? '0 : mem[idx];
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (access && a_wen && !fault)
      for (int i = 0; i < 4; i++)
        if (a_wmask[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ysyx_dmem_responder.sv
// tb_ysyx_dmem_responder: directed + random checks of two responder builds (LATENCY=2 and LATENCY=1) against a word-array model
module tb_ysyx_dmem_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 1024;
  logic clk = 0, rst = 1, sel = 0;
  logic req_valid = 0, req_wen = 0, rsp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_wmask = 0;
  logic rdy0, rdy1, vld0, vld1, err0, err1;
  logic [31:0] rd0, rd1;
  logic rdy, vld, err;
  logic [31:0] rdata;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mm [int];
  always #5 clk = ~clk;
  assign rdy = sel ? rdy1 : rdy0;
  assign vld = sel ? vld1 : vld0;
  assign err = sel ? err1 : err0;
  assign rdata = sel ? rd1 : rd0;
  ysyx_dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rdy0), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(vld0),
    .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(err0));
  ysyx_dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rdy1), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(vld1),
    .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(err1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] m, output logic [31:0] erd, output logic eerr);
    longint ua = longint'(a);
    int key;
    logic [31:0] old;
    eerr = ua < longint'(BASE) || ua >= longint'(BASE) + 4 * DEPTH || a % 4 != 0;
    erd = 0;
    if (eerr) return;
    key = int'((ua - longint'(BASE)) / 4) + (s ? 65536 : 0);
    old = mm.exists(key) ? mm[key] : 'x;
    if (w) begin
      for (int i = 0; i < 4; i++) if (m[i]) old[8*i +: 8] = d[8*i +: 8];
      mm[key] = old;
    end else erd = old;
  endfunction
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                        output logic [31:0] ord, output logic oerr);
    int cyc = 0;
    @(negedge clk);
    chk("req_ready_idle", 32'(rdy), 1);
    req_valid = 1; req_wen = w; req_addr = a; req_wdata = d; req_wmask = m;
    @(posedge clk);
    #1 req_valid = 0; req_wen = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom);
    while (cyc < 20) begin
      @(negedge clk);
      if (vld) break;
      @(posedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), sel ? 0 : 1);
    chk("busy_not_ready", 32'(rdy), 0);
    ord = rdata; oerr = err;
    @(posedge clk);
    @(negedge clk);
    chk("back_idle", {30'd0, vld, rdy}, 1);
  endtask
  task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] erd, ord;
    logic eerr, oerr;
    model(sel, w, a, d, m, erd, eerr);
    do_req(w, a, d, m, ord, oerr);
    chk({tag, "_err"}, 32'(oerr), 32'(eerr));
    chk({tag, "_rdata"}, ord, erd);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a, cap_rd, erd, ord;
    logic cap_err, eerr, oerr;
    int cyc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, vld0}, 0);
    chk("rst_rdata", rd0, 0);
    chk("rst_err", {31'd0, err0}, 0);
    chk("rst_ready", {31'd0, rdy0}, 1);
    chk("rst_valid_l1", {31'd0, vld1}, 0);
    rst = 0;
    for (int i = 0; i < 16; i++) txn("init", 1, BASE + 32'(4 * i), $urandom, 4'hF);
    txn("wr_beef", 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    txn("rd_beef", 0, 32'h8000_0010, 0, 0);
    txn("wr_mask", 1, 32'h8000_0010, 32'h1122_3344, 4'b0101);
    model(0, 0, 32'h8000_0010, 0, 0, erd, eerr);
    chk("mask_model", erd, 32'hDE22_BE44);
    do_req(0, 32'h8000_0010, 0, 0, ord, oerr);
    chk("rd_mask", ord, 32'hDE22_BE44);
    txn("misaligned", 0, 32'h8000_0012, 0, 0);
    txn("below_base", 0, 32'h7FFF_FFFC, 0, 0);
    txn("above_top", 1, 32'h8000_1000, 32'h5555_AAAA, 4'hF);
    txn("word0_unchanged", 0, 32'h8000_0000, 0, 0);
    txn("wr_nomask", 1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0);
    txn("rd_nomask", 0, 32'h8000_0004, 0, 0);
    txn("last_word_wr", 1, BASE + 32'(4 * DEPTH - 4), 32'h0BAD_CAFE, 4'hF);
    txn("last_word_rd", 0, BASE + 32'(4 * DEPTH - 4), 0, 0);
    model(0, 0, 32'h8000_0010, 0, 0, erd, eerr);
    @(negedge clk);
    rsp_ready = 0;
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0010; req_wmask = 0;
    @(posedge clk);
    #1 req_valid = 0;
    cyc = 0;
    while (cyc < 10 && !vld) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_got_rsp", {31'd0, vld}, 1);
    cap_rd = rdata; cap_err = err;
    chk("bp_rdata", cap_rd, erd);
    req_valid = 1; req_wen = 1; req_wdata = 32'h7777_7777; req_wmask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, vld}, 1);
      chk("bp_stable_rdata", rdata, cap_rd);
      chk("bp_stable_err", {31'd0, err}, {31'd0, cap_err});
      chk("bp_ready_low", {31'd0, rdy}, 0);
    end
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    chk("bp_release", {30'd0, vld, rdy}, 1);
    @(negedge clk);
    chk("bp_no_accept", {30'd0, vld, rdy}, 1);
    txn("bp_mem_unchanged", 0, 32'h8000_0010, 0, 0);
    @(negedge clk);
    req_valid = 1; req_wen = 1; req_addr = 32'h8000_0020; req_wdata = 32'hCAFE_F00D; req_wmask = 4'hF;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_busy_valid", {31'd0, vld}, 0);
    chk("rst_busy_ready", {31'd0, rdy}, 1);
    @(negedge clk);
    rst = 0;
    txn("rst_busy_old", 0, 32'h8000_0020, 0, 0);
    for (int i = 0; i < 40; i++) begin
      a = BASE + 32'(4 * $urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0: a = a + 32'($urandom_range(1, 3));
        1: a = BASE - 32'(4 * $urandom_range(1, 4));
        2: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        default: ;
      endcase
      txn("rand", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    end
    sel = 1;
    txn("l1_wr", 1, 32'h8000_0040, 32'h1234_5678, 4'hF);
    txn("l1_rd", 0, 32'h8000_0040, 0, 0);
    txn("l1_wr_mask", 1, 32'h8000_0040, 32'hAABB_CCDD, 4'b1010);
    txn("l1_rd_mask", 0, 32'h8000_0040, 0, 0);
    txn("l1_fault", 0, 32'h8000_0041, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
